// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register built as a two-entry skid buffer (main M, skid S).
// in_ready comes straight from the skid valid flop, so there is no out_ready->in_ready path.
module mem_wb_stage #(
    parameter int CTRL_W    = 10,
    parameter int DATA_W    = 32,
    parameter int RD_W      = 5,
    parameter int REGWR_BIT = 0,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_memval,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_memval,
    output logic [DATA_W-1:0] out_alu,
    output logic [RD_W-1:0]   out_rd,
    output logic              fwd_en,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] memval;
        logic [DATA_W-1:0] alu;
        logic [RD_W-1:0]   rd;
    } beat_t;

    beat_t            m_q, m_d, s_q, s_d, in_beat;
    logic             m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             accept, consume;

    assign in_beat = {in_ctrl, in_memval, in_alu, in_rd};
    assign accept  = in_valid & ~s_valid_q;
    assign consume = m_valid_q & out_ready;

    // NOTE: every variable gets its hold value first so no path through this block infers a latch.
    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        stall_d   = stall_q;

        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            m_d.ctrl  = '0;
            s_d.ctrl  = '0;
        end else if (s_valid_q) begin
            // Skid full: nothing can be accepted, only drain S into M.
            if (consume) begin
                m_d       = s_q;
                s_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!m_valid_q || out_ready) begin
                m_d       = in_beat;
                m_valid_d = 1'b1;
            end else begin
                s_d       = in_beat;
                s_valid_d = 1'b1;
            end
        end else if (consume) begin
            m_valid_d = 1'b0;
        end

        if (m_valid_q && !out_ready && stall_q != '1) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // NOTE: payload registers are reset too, so outputs read all-zero while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            stall_q   <= stall_d;
        end
    end

    assign in_ready   = ~s_valid_q;
    assign out_valid  = m_valid_q;
    assign out_ctrl   = m_q.ctrl;
    assign out_memval = m_q.memval;
    assign out_alu    = m_q.alu;
    assign out_rd     = m_q.rd;
    assign fwd_en     = m_valid_q & m_q.ctrl[REGWR_BIT] & (m_q.rd != '0);
    assign stall_cnt  = stall_q;

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter CTRL_W, default 10, SHALL set the control-signal field width in bits.
REQ-002 Parameter DATA_W, default 32, SHALL set the width in bits of the memval and alu fields.
REQ-003 Parameter RD_W, default 5, SHALL set the destination-register index width in bits.
REQ-004 Parameter REGWR_BIT, default 0, SHALL select the ctrl bit that means register-write enable.
REQ-005 Parameter CNT_W, default 16, SHALL set the stall-counter width in bits.
REQ-006 Port clk, input, 1, SHALL be the single clock; all state updates occur on its rising edge.
REQ-007 Port rst_n, input, 1, SHALL be the reset: asynchronous and active-low.
REQ-008 Port in_valid, input, 1, SHALL mark a valid beat from the MEM stage.
REQ-009 Port in_ready, output, 1, SHALL indicate that the stage accepts a beat this cycle.
REQ-010 Ports in_ctrl (CTRL_W), in_memval (DATA_W), in_alu (DATA_W) and in_rd (RD_W), all inputs, SHALL carry the MEM-stage payload.
REQ-011 Port flush, input, 1, SHALL be a synchronous kill of all held and incoming beats.
REQ-012 Port out_valid, output, 1, SHALL mark a valid beat presented to the WB stage.
REQ-013 Port out_ready, input, 1, SHALL indicate that the WB stage consumes the beat this cycle.
REQ-014 Ports out_ctrl (CTRL_W), out_memval (DATA_W), out_alu (DATA_W) and out_rd (RD_W), all outputs, SHALL carry the WB-stage payload.
REQ-015 Port fwd_en, output, 1, SHALL be the forwarding qualifier for the hazard unit.
REQ-016 Port stall_cnt, output, CNT_W, SHALL report the count of back-pressure cycles.

Function
REQ-017 Storage SHALL be exactly two entries: a main register M that drives the out_* ports, and a skid register S; each entry has its own valid bit (Mv, Sv).
REQ-018 in_ready SHALL equal ~Sv and SHALL be driven directly from a flop, with no combinational path from out_ready.
REQ-019 A beat SHALL be accepted when in_valid & in_ready, and SHALL be consumed when out_valid & out_ready.
REQ-020 out_valid SHALL equal Mv; the out_* payload SHALL be M's fields.
REQ-021 When accepting a beat and M is empty or being consumed, with Sv=0, the beat SHALL load into M; latency is 1 cycle.
REQ-022 When accepting a beat while Mv=1 and out_ready=0, the beat SHALL load into S; M SHALL hold.
REQ-023 When M is consumed and Sv=1, S SHALL move to M and Sv SHALL clear in the same cycle (in_ready is 0 that cycle, so no new beat enters).
REQ-024 Beats SHALL leave in acceptance order; none SHALL be dropped or duplicated; with out_ready held at 1 the stage SHALL sustain 1 beat/cycle.
REQ-025 flush=1 SHALL, at the next edge, clear Mv and Sv, set both ctrl fields to 0, and discard any beat accepted in that cycle. flush SHALL take priority over every load or move.
REQ-026 fwd_en SHALL equal Mv & M.ctrl[REGWR_BIT] & (M.rd != 0).
REQ-027 stall_cnt SHALL increment by 1 on each cycle with out_valid=1 and out_ready=0, saturate at all-ones, and be unaffected by flush.
REQ-028 Payload fields other than ctrl SHALL hold their last value when the entry is invalid.

Reset
REQ-029 rst_n=0 SHALL immediately, with no clock edge, clear Mv, Sv, all payload fields and stall_cnt to 0; it SHALL also force in_ready=1 and fwd_en=0.
REQ-030 An assertion of rst_n in the middle of a transfer SHALL lose all held beats; the first accept after release SHALL load into M.
REQ-031 Reset release SHALL be synchronous to clk by the surrounding design; the stage SHALL accept a beat on the first edge after release.

Verification
REQ-032 Reset, then stream 4 beats (alu=1..4) with out_ready=1 -> out_valid each cycle from cycle 1, alu 1,2,3,4 in order, in_ready stays 1.
REQ-033 Hold out_ready=0 and offer beats A then B -> A in M and B in S, in_ready=0, stall_cnt counts up; raise out_ready -> A then B out on consecutive cycles, in_ready=1 after B moves.
REQ-034 Pulse flush with M and S full and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, no stale beat emerges later.
REQ-035 Beat with ctrl[0]=1 and rd=0, then rd=7 -> fwd_en=0, then 1; same beat with ctrl[0]=0 -> fwd_en=0.
REQ-036 Set CNT_W=4 and hold out_ready=0 for 20 cycles -> stall_cnt saturates at 15; assert rst_n=0 mid-stream -> all outputs 0 and in_ready=1 without a clock edge.
